// File: rtl/sequential_binary_divider.sv
`default_nettype none
// ============================================================================
// Module   : sequential_binary_divider
// Purpose  : Multi-cycle restoring divider. Divides a 2*dp_width-bit dividend
//            by a dp_width-bit divisor, giving a dp_width-bit quotient and
//            remainder. One-hot idle/shift/sub controller driving an A/Q/E
//            shift datapath. The Start/Ready handshake matches the shift-add
//            multiplier, so a product can be fed straight back as a dividend.
// Ports    : clock       - sole clock, rising edge
//            reset       - synchronous, active-high
//            Dividend    - [2*dp_width-1:0], sampled on an accepted Start
//            Divisor     - [dp_width-1:0], sampled on an accepted Start
//            Start       - request, accepted only while Ready=1
//            Quotient    - [dp_width-1:0], register Q
//            Remainder   - [dp_width-1:0], register A
//            Ready       - high while idle
//            Div_by_zero - registered error flag
//            Overflow    - registered error flag
// Revision : 1.0 - initial release
// ============================================================================
module sequential_binary_divider #(
  parameter int dp_width = 4,
  parameter int BC_size  = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2*dp_width-1:0]   Dividend,
  input  logic [dp_width-1:0]     Divisor,
  input  logic                    Start,
  output logic [dp_width-1:0]     Quotient,
  output logic [dp_width-1:0]     Remainder,
  output logic                    Ready,
  output logic                    Div_by_zero,
  output logic                    Overflow
);

  typedef enum logic [2:0] {
    S_idle  = 3'b001,
    S_shift = 3'b010,
    S_sub   = 3'b100
  } state_t;

  localparam logic [BC_size-1:0] C_COUNT_INIT = BC_size'(dp_width);
  localparam logic [BC_size-1:0] C_COUNT_ONE  = BC_size'(1);

  state_t                state_q, state_d;
  logic [dp_width-1:0]   a_q, a_d;
  logic [dp_width-1:0]   q_q, q_d;
  logic [dp_width-1:0]   b_q, b_d;
  logic                  e_q, e_d;
  logic [BC_size-1:0]    p_q, p_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;

  // Partial remainder including the carry shifted out of A. Comparing and
  // subtracting at N+1 bits keeps that carry from being lost.
  logic [dp_width:0]     ea;
  logic                  sub_ok;
  logic [dp_width-1:0]   a_sub;

  always_comb begin
    ea     = {e_q, a_q};
    sub_ok = (ea >= {1'b0, b_q});
    a_sub  = dp_width'(ea - {1'b0, b_q});
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    b_d     = b_q;
    e_d     = e_q;
    p_d     = p_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_idle: begin
        if (Start) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (Divisor == '0) begin
            dbz_d = 1'b1;
            ovf_d = 1'b1;
            a_d   = '0;
            q_d   = '0;
          end else if (Dividend[2*dp_width-1:dp_width] >= Divisor) begin
            // Quotient would need more than dp_width bits.
            ovf_d = 1'b1;
            a_d   = '0;
            q_d   = '0;
          end else begin
            a_d     = Dividend[2*dp_width-1:dp_width];
            q_d     = Dividend[dp_width-1:0];
            b_d     = Divisor;
            e_d     = 1'b0;
            p_d     = C_COUNT_INIT;
            state_d = S_shift;
          end
        end
      end

      S_shift: begin
        {e_d, a_d, q_d} = {a_q, q_q, 1'b0};
        state_d         = S_sub;
      end

      S_sub: begin
        if (sub_ok) begin
          a_d    = a_sub;
          q_d[0] = 1'b1;
        end
        e_d     = 1'b0;
        p_d     = p_q - C_COUNT_ONE;
        state_d = (p_q == C_COUNT_ONE) ? S_idle : S_shift;
      end

      default: begin
        state_d = S_idle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_idle;
      a_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      e_q     <= 1'b0;
      p_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      b_q     <= b_d;
      e_q     <= e_d;
      p_q     <= p_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Quotient    = q_q;
  assign Remainder   = a_q;
  assign Ready       = (state_q == S_idle);
  assign Div_by_zero = dbz_q;
  assign Overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sequential_binary_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequential_binary_divider
// Purpose  : Self-checking bench for sequential_binary_divider (dp_width=4).
//            Directed vector table, back-to-back, mid-operation reset and an
//            exhaustive sweep of every dividend/divisor pair.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequential_binary_divider;

  logic       clock;
  logic       reset;
  logic [7:0] Dividend;
  logic [3:0] Divisor;
  logic       Start;
  logic [3:0] Quotient;
  logic [3:0] Remainder;
  logic       Ready;
  logic       Div_by_zero;
  logic       Overflow;

  int checks;
  int failures;

  sequential_binary_divider #(
    .dp_width (4),
    .BC_size  (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .Start       (Start),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .Ready       (Ready),
    .Div_by_zero (Div_by_zero),
    .Overflow    (Overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] dd;
    logic [3:0] dv;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    logic       ovf;
    int         busy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Starts and ends on a negedge. Inputs are scrambled while busy to show
  // they are not re-sampled mid-operation.
  task automatic run_op(input logic [7:0] dd, input logic [3:0] dv,
                        output logic [3:0] q, output logic [3:0] r,
                        output logic dbz, output logic ovf, output int busy);
    Dividend = dd;
    Divisor  = dv;
    Start    = 1'b1;
    @(negedge clock);
    Start    = 1'b0;
    Dividend = ~dd;
    Divisor  = ~dv;
    busy     = 0;
    while (!Ready && busy < 40) begin
      busy++;
      @(negedge clock);
    end
    q   = Quotient;
    r   = Remainder;
    dbz = Div_by_zero;
    ovf = Overflow;
  endtask

  initial begin
    logic [3:0] q, r;
    logic       dbz, ovf;
    int         busy;
    logic       rdy_seen [18];
    logic       rdy_exp;
    logic [3:0] exp_q, exp_r;
    logic       exp_dbz, exp_ovf;
    int         exp_busy;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    Start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;

    //         dd      dv     q      r      dbz   ovf   busy
    vecs[0] = '{8'd100, 4'd7,  4'd14, 4'd2,  1'b0, 1'b0, 8};
    vecs[1] = '{8'd239, 4'd15, 4'd15, 4'd14, 1'b0, 1'b0, 8};
    vecs[2] = '{8'd50,  4'd0,  4'd0,  4'd0,  1'b1, 1'b1, 0};
    vecs[3] = '{8'd100, 4'd7,  4'd14, 4'd2,  1'b0, 1'b0, 8};
    vecs[4] = '{8'd112, 4'd7,  4'd0,  4'd0,  1'b0, 1'b1, 0};
    vecs[5] = '{8'd127, 4'd8,  4'd15, 4'd7,  1'b0, 1'b0, 8};
    vecs[6] = '{8'd17,  4'd3,  4'd5,  4'd2,  1'b0, 1'b0, 8};
    vecs[7] = '{8'd9,   4'd9,  4'd1,  4'd0,  1'b0, 1'b0, 8};
    vecs[8] = '{8'd0,   4'd1,  4'd0,  4'd0,  1'b0, 1'b0, 8};
    vecs[9] = '{8'd255, 4'd15, 4'd0,  4'd0,  1'b0, 1'b1, 0};

    // Reset state
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("reset_ready", 32'(Ready), 32'd1);
    chk("reset_quotient", 32'(Quotient), 32'd0);
    chk("reset_remainder", 32'(Remainder), 32'd0);
    chk("reset_flags", {30'd0, Div_by_zero, Overflow}, 32'd0);

    // Directed table; vector 3 follows an error case so it also shows
    // a valid Start clearing both flags.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].dd, vecs[i].dv, q, r, dbz, ovf, busy);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("vec%0d_dbz", i), 32'(dbz), 32'(vecs[i].dbz));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
    end

    // Results persist while idle with Start low
    repeat (5) @(negedge clock);
    chk("hold_quotient", 32'(Quotient), 32'd0);
    chk("hold_ovf", 32'(Overflow), 32'd1);

    // Start held high: Ready low 8 cycles, high exactly 1, then low again
    Dividend = 8'd100;
    Divisor  = 4'd7;
    Start    = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      rdy_seen[i] = Ready;
      if (i == 8) begin
        chk("b2b_quotient", 32'(Quotient), 32'd14);
        chk("b2b_remainder", 32'(Remainder), 32'd2);
      end
    end
    Start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      rdy_exp = (i == 8 || i == 17);
      chk($sformatf("b2b_ready_c%0d", i), 32'(rdy_seen[i]), 32'(rdy_exp));
    end
    chk("b2b_final_quotient", 32'(Quotient), 32'd14);
    chk("b2b_final_remainder", 32'(Remainder), 32'd2);

    // Reset on the 3rd busy cycle
    Dividend = 8'd100;
    Divisor  = 4'd7;
    Start    = 1'b1;
    @(negedge clock);
    Start = 1'b0;
    chk("rst_mid_busy1", 32'(Ready), 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("rst_mid_busy3", 32'(Ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_mid_ready", 32'(Ready), 32'd1);
    chk("rst_mid_quotient", 32'(Quotient), 32'd0);
    chk("rst_mid_remainder", 32'(Remainder), 32'd0);
    chk("rst_mid_flags", {30'd0, Div_by_zero, Overflow}, 32'd0);
    run_op(8'd100, 4'd7, q, r, dbz, ovf, busy);
    chk("rst_after_op", {16'd0, 4'(busy), q, r, 2'b00, dbz, ovf}, {16'd0, 4'd8, 4'd14, 4'd2, 4'd0});

    // Exhaustive sweep of every dividend/divisor pair
    for (int dd = 0; dd < 256; dd++) begin
      for (int dv = 0; dv < 16; dv++) begin
        if (dv == 0) begin
          exp_q = 0; exp_r = 0; exp_dbz = 1; exp_ovf = 1; exp_busy = 0;
        end else if ((dd / 16) >= dv) begin
          exp_q = 0; exp_r = 0; exp_dbz = 0; exp_ovf = 1; exp_busy = 0;
        end else begin
          exp_q = 4'(dd / dv); exp_r = 4'(dd % dv);
          exp_dbz = 0; exp_ovf = 0; exp_busy = 8;
        end
        run_op(8'(dd), 4'(dv), q, r, dbz, ovf, busy);
        chk($sformatf("sweep_%0d_by_%0d {busy,q,r,dbz,ovf}", dd, dv),
            {16'd0, 4'(busy), q, r, 2'b00, dbz, ovf},
            {16'd0, 4'(exp_busy), exp_q, exp_r, 2'b00, exp_dbz, exp_ovf});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
